// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_runner slice.
//   uart_state_e         - four-phase frame state used by both RX and TX FSMs
//   DEFAULT_CLKS_PER_BIT - default bit period in clk_i cycles
//   UART_DATA_W          - data bits per frame (fixed at 8)
//   cnt_width()          - width of a counter that counts 0 .. clks_per_bit-1
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int UART_DATA_W          = 8;

  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter with a ready/valid byte interface.
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   tx_data_i     - byte to send, captured when tx_valid_i && tx_ready_o
//   tx_valid_i    - transmit request
//   tx_ready_o    - high while the FSM is in IDLE
//   tx_o          - registered serial output, idle high
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  uart_state_e       r_state, w_state_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;
  logic [BW-1:0]     r_bit, w_bit_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic              r_tx, w_tx_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  // tx_o is registered, so the next line level is computed together with
  // the state change that starts each bit.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (tx_valid_i) begin
          w_state_next = START;
          w_shift_next = tx_data_i;
          w_tx_next    = 1'b0;
        end
      end
      START: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = DATA;
          w_cnt_next   = '0;
          w_bit_next   = '0;
          w_tx_next    = r_shift[0];
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next = '0;
          if (r_bit == BIT_LAST) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            // Shift out the bit just sent; the next one is r_shift[1].
            w_bit_next   = r_bit + BW'(1);
            w_shift_next = r_shift >> 1;
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  assign tx_ready_o = (r_state == IDLE);
  assign tx_o       = r_tx;

endmodule

// File: rtl/uart_runner.sv
// uart_runner: full-duplex 8N1 UART endpoint (inline oversampling RX + uart_tx).
// Ports:
//   clk_i, rst_i    - clock, synchronous active-high reset
//   rx_i            - asynchronous serial input, idle high
//   tx_o            - serial output, idle high
//   rx_data_o       - last good received byte
//   rx_valid_o      - one-cycle pulse when rx_data_o updates
//   rx_frame_err_o  - one-cycle pulse when a stop bit samples low
//   tx_data_i/tx_valid_i/tx_ready_o - transmit byte ready/valid interface
// Optional build macro UART_ECHO_EN: every received byte is also queued to
// the transmitter through a 1-entry, last-wins echo register that takes
// priority over tx_valid_i and holds tx_ready_o low while occupied.
module uart_runner
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic              tx_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              rx_frame_err_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  // ---------------- RX ----------------
  logic [1:0]        r_rx_sync;
  logic              w_rx;
  uart_state_e       r_rx_state, w_rx_state_next;
  logic [CW-1:0]     r_rx_cnt, w_rx_cnt_next;
  logic [BW-1:0]     r_rx_bit, w_rx_bit_next;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift_next;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_next;
  logic              r_rx_valid, w_rx_valid_next;
  logic              r_rx_ferr, w_rx_ferr_next;

  assign w_rx = r_rx_sync[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_sync  <= 2'b11;  // idle line level, so reset never looks like a start bit
      r_rx_state <= IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], rx_i};
      r_rx_state <= w_rx_state_next;
      r_rx_cnt   <= w_rx_cnt_next;
      r_rx_bit   <= w_rx_bit_next;
      r_rx_shift <= w_rx_shift_next;
      r_rx_data  <= w_rx_data_next;
      r_rx_valid <= w_rx_valid_next;
      r_rx_ferr  <= w_rx_ferr_next;
    end
  end

  // After the half-bit START wait, every later sample lands mid-bit.
  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_cnt_next   = r_rx_cnt;
    w_rx_bit_next   = r_rx_bit;
    w_rx_shift_next = r_rx_shift;
    w_rx_data_next  = r_rx_data;
    w_rx_valid_next = 1'b0;
    w_rx_ferr_next  = 1'b0;
    case (r_rx_state)
      IDLE: begin
        w_rx_cnt_next = '0;
        if (!w_rx) w_rx_state_next = START;
      end
      START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_bit_next   = '0;
          // A line already high again at mid start bit was only a glitch.
          w_rx_state_next = w_rx ? IDLE : DATA;
        end else begin
          w_rx_cnt_next = r_rx_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_next   = '0;
          w_rx_shift_next = {w_rx, r_rx_shift[DATA_W-1:1]};
          if (r_rx_bit == BIT_LAST) w_rx_state_next = STOP;
          else                      w_rx_bit_next   = r_rx_bit + BW'(1);
        end else begin
          w_rx_cnt_next = r_rx_cnt + CW'(1);
        end
      end
      STOP: begin
        if (r_rx_cnt == CNT_LAST) begin
          // Leave mid stop bit so a frame starting right after is not missed.
          w_rx_state_next = IDLE;
          w_rx_cnt_next   = '0;
          if (w_rx) begin
            w_rx_data_next  = r_rx_shift;
            w_rx_valid_next = 1'b1;
          end else begin
            w_rx_ferr_next = 1'b1;
          end
        end else begin
          w_rx_cnt_next = r_rx_cnt + CW'(1);
        end
      end
      default: w_rx_state_next = IDLE;
    endcase
  end

  assign rx_data_o      = r_rx_data;
  assign rx_valid_o     = r_rx_valid;
  assign rx_frame_err_o = r_rx_ferr;

  // ---------------- TX ----------------
  logic [DATA_W-1:0] w_txc_data;
  logic              w_txc_valid;
  logic              w_txc_ready;

`ifdef UART_ECHO_EN
  logic              r_echo_full;
  logic [DATA_W-1:0] r_echo_data;

  // Loaded on the same edge rx_valid_o rises; a new byte overwrites any
  // pending one, and a load beats a same-cycle hand-off to the transmitter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_echo_full <= 1'b0;
      r_echo_data <= '0;
    end else if (w_rx_valid_next) begin
      r_echo_full <= 1'b1;
      r_echo_data <= r_rx_shift;
    end else if (r_echo_full && w_txc_ready) begin
      r_echo_full <= 1'b0;
    end
  end

  assign w_txc_valid = r_echo_full | tx_valid_i;
  assign w_txc_data  = r_echo_full ? r_echo_data : tx_data_i;
  assign tx_ready_o  = w_txc_ready & ~r_echo_full;
`else
  assign w_txc_valid = tx_valid_i;
  assign w_txc_data  = tx_data_i;
  assign tx_ready_o  = w_txc_ready;
`endif

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_tx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tx_data_i  (w_txc_data),
    .tx_valid_i (w_txc_valid),
    .tx_ready_o (w_txc_ready),
    .tx_o       (tx_o)
  );

endmodule

// File: tb/tb_uart_runner.sv
// tb_uart_runner: randomized + directed bench for uart_runner (CLKS_PER_BIT=16).
// The reference model treats a frame as the list {0, data LSB first, stop}
// and derives expected bytes, error pulses and line levels from that.
module tb_uart_runner;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       ferr;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;

  uart_runner #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_i           (rx),
    .tx_o           (tx),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_frame_err_o (ferr),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observers, sampled on the falling edge.
  logic [7:0] rx_q[$];
  int rx_valid_cyc = 0;
  int ferr_cnt = 0;
  int tx_low_cnt = 0;
  int low_run = 0;
  int last_low_run = 0;
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_q.push_back(rx_data);
      rx_valid_cyc = cyc;
    end
    if (ferr === 1'b1) ferr_cnt++;
    if (tx === 1'b0) tx_low_cnt++;
    if (tx_ready === 1'b0) low_run++;
    else begin
      if (low_run != 0) last_low_run = low_run;
      low_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop_bit, output int fall_cyc);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    @(posedge clk); #1;
    fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  // Waits (bounded) for a start bit on tx_o and checks every cycle of every bit.
  task automatic tx_expect(input logic [7:0] d, output int start_cyc);
    logic [9:0] fr;
    logic seen;
    int w;
    fr = {1'b1, d, 1'b0};
    w = 0;
    start_cyc = 0;
    @(negedge clk);
    while (tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("tx_start_seen", 32'(w < 400), 32'd1);
    if (w < 400) begin
      start_cyc = cyc;
      for (int b = 0; b < 10; b++) begin
        seen = fr[b];
        for (int c = 0; c < CPB; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (tx !== fr[b]) seen = tx;
        end
        check($sformatf("tx_%02h_bit%0d", d, b), 32'(seen), 32'(fr[b]));
      end
      $display("tx frame 0x%02h checked, start at cycle %0d", d, start_cyc);
    end
  endtask

  task automatic rx_expect_good(input string tag, input logic [7:0] d, input int fc);
    int lat;
    check({tag, "_count"}, 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check({tag, "_data"}, 32'(rx_q.pop_front()), 32'(d));
    lat = rx_valid_cyc - fc;
    check({tag, "_latency_window"}, 32'(lat >= 153 && lat <= 163), 32'd1);
    $display("rx frame 0x%02h latency %0d cycles", d, lat);
  endtask

  initial begin
    int fc, f0, s1, s2, v, w, t0, q0;
    logic [7:0] d, last_good;
    logic sb;

    // ---- reset ----
    rst = 1'b1; rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tx_o", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    repeat (256) @(posedge clk);
    #1;
    check("rst_no_rx_valid", 32'(rx_q.size()), 32'd0);
    check("rst_no_ferr", 32'(ferr_cnt), 32'd0);

    // ---- RX 0xAC ----
    rx_send(8'hAC, 1'b1, fc);
    rx_expect_good("rx_ac", 8'hAC, fc);
    check("rx_ac_no_ferr", 32'(ferr_cnt), 32'd0);
    last_good = 8'hAC;

    // ---- RX stop bit low, then 0x55 ----
    f0 = ferr_cnt;
    rx_send(8'h3B, 1'b0, fc);
    check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_valid", 32'(rx_q.size()), 32'd0);
    check("ferr_data_kept", 32'(rx_data), 32'(last_good));
    repeat (2 * CPB) @(posedge clk);
    rx_send(8'h55, 1'b1, fc);
    rx_expect_good("rx_55", 8'h55, fc);
    last_good = 8'h55;

    // ---- start glitch, then 0x3C ----
    f0 = ferr_cnt;
    @(posedge clk); #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check("glitch_no_valid", 32'(rx_q.size()), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    rx_send(8'h3C, 1'b1, fc);
    rx_expect_good("rx_3c", 8'h3C, fc);
    last_good = 8'h3C;

    // ---- random RX frames against the model ----
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      f0 = ferr_cnt;
      rx_send(d, sb, fc);
      if (sb) begin
        rx_expect_good($sformatf("rnd%0d", i), d, fc);
        check($sformatf("rnd%0d_no_ferr", i), 32'(ferr_cnt - f0), 32'd0);
        last_good = d;
      end else begin
        check($sformatf("rnd%0d_ferr", i), 32'(ferr_cnt - f0), 32'd1);
        check($sformatf("rnd%0d_no_valid", i), 32'(rx_q.size()), 32'd0);
        check($sformatf("rnd%0d_data_kept", i), 32'(rx_data), 32'(last_good));
        $display("rx frame 0x%02h with low stop bit -> frame error", d);
        repeat (2 * CPB) @(posedge clk);
      end
    end

`ifndef UART_ECHO_EN
    check("no_echo_tx_idle", 32'(tx_low_cnt), 32'd0);
`else
    repeat (400) @(posedge clk);  // let pending echoes drain
`endif

    // ---- TX 0xA5 then 0x0F back-to-back ----
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(posedge clk); #1 tx_data = 8'h0F;  // valid stays high, ignored until ready
    tx_expect(8'hA5, s1);
    @(negedge clk);
    check("tx_ready_back", 32'(tx_ready), 32'd1);
    @(posedge clk); #1 tx_valid = 1'b0;
    check("tx_ready_low_cycles", 32'(last_low_run), 32'd160);
    tx_expect(8'h0F, s2);
    check("tx_second_start_gap", 32'(s2 - s1), 32'd161);

    // ---- random TX bytes ----
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      w = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && w < 400) begin @(negedge clk); w++; end
      check("tx_rnd_ready_wait", 32'(w < 400), 32'd1);
      tx_valid = 1'b1; tx_data = d;
      @(posedge clk); #1 tx_valid = 1'b0;
      tx_expect(d, s1);
    end

`ifdef UART_ECHO_EN
    // ---- echo: RX 0xAC retransmitted, simultaneous 0x11 rejected ----
    repeat (4 * CPB) @(posedge clk);
    fork
      rx_send(8'hAC, 1'b1, fc);
      begin
        w = 0;
        @(negedge clk);
        while (rx_valid !== 1'b1 && w < 400) begin @(negedge clk); w++; end
        check("echo_rx_seen", 32'(w < 400), 32'd1);
        v = cyc;
        tx_valid = 1'b1; tx_data = 8'h11;
        @(posedge clk); #1 tx_valid = 1'b0;
        tx_expect(8'hAC, s1);
        check("echo_start_within_2", 32'((s1 - v) <= 2), 32'd1);
      end
    join
    if (rx_q.size() > 0) void'(rx_q.pop_front());
    @(posedge clk); #1;
    t0 = tx_low_cnt;
    repeat (300) @(posedge clk);
    check("echo_0x11_not_sent", 32'(tx_low_cnt - t0), 32'd0);
`endif

    // ---- reset mid-frame on both directions ----
    q0 = rx_q.size();
    f0 = ferr_cnt;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h00;
    @(posedge clk); #1 tx_valid = 1'b0;
    fork
      rx_send(8'hFF, 1'b1, fc);
      begin
        repeat (80) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_tx_o", 32'(tx), 32'd1);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
      end
    join
    t0 = tx_low_cnt;
    repeat (200) @(posedge clk);
    #1;
    check("midrst_no_rx_valid", 32'(rx_q.size() - q0), 32'd0);
    check("midrst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("midrst_tx_stays_idle", 32'(tx_low_cnt - t0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
